// File: rtl/nes_cpu_pkg.sv
// Shared CPU-pipeline definitions: fetch FSM states, reset vector addresses and
// the field layout of the fetch-to-decode instruction register.
package nes_cpu_pkg;

    typedef enum logic [2:0] {
        VEC_LO   = 3'd0,
        VEC_HI   = 3'd1,
        FETCH_OP = 3'd2,
        FETCH_B1 = 3'd3,
        FETCH_B2 = 3'd4,
        HOLD     = 3'd5
    } fetch_state_t;

    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;

    localparam int unsigned FD_OP_LSB = 16;
    localparam int unsigned FD_B1_LSB = 8;
    localparam int unsigned FD_B2_LSB = 0;

    function automatic logic [23:0] pack_fd(input logic [7:0] op,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
        logic [23:0] r;
        r = '0;
        r[FD_OP_LSB +: 8] = op;
        r[FD_B1_LSB +: 8] = b1;
        r[FD_B2_LSB +: 8] = b2;
        return r;
    endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// Instruction length (1..3 bytes) from the opcode byte.
module fetch_len_decode (
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = 2'd2;
        if (opcode[3:0] == 4'h8 || opcode[3:0] == 4'hA ||
            opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
            len = 2'd1;
        end else if (opcode[3:2] == 2'b11 ||
                     (opcode[4] && (opcode[3:0] == 4'h9 || opcode[3:0] == 4'hB)) ||
                     opcode == 8'h20) begin
            len = 2'd3;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Byte-serial instruction fetch with a one-instruction output holding register.
// Define NES_RESET_VECTOR_EN to load the start PC from the FFFC/FFFD reset vector.
module fetch_stage
    import nes_cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata,
    output logic [23:0] f_to_d_reg,
    output logic        f_to_d_valid,
    input  logic        d_ready,
    output logic [15:0] pc_out,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc
);

    fetch_state_t state;
    logic         run;
    logic [15:0]  pc;
    logic [7:0]   op_q;
    logic [7:0]   b1_q;
    logic [1:0]   len_q;
    logic [1:0]   rd_len;
    logic         redirect_ok;
`ifdef NES_RESET_VECTOR_EN
    logic         vec_wait;
`endif

    fetch_len_decode u_len (
        .opcode (mem_rdata),
        .len    (rd_len)
    );

`ifdef NES_RESET_VECTOR_EN
    assign redirect_ok = redirect_valid && state != VEC_LO && state != VEC_HI;
`else
    assign redirect_ok = redirect_valid;
`endif

    // run holds the bus idle for the first cycle after reset so that the
    // reset-state outputs read as zero.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        if (run) begin
            case (state)
                FETCH_OP: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc;
                end
                FETCH_B1: if (rd_len != 2'd1) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc + 16'd1;
                end
                FETCH_B2: if (len_q == 2'd3) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = pc + 16'd2;
                end
`ifdef NES_RESET_VECTOR_EN
                VEC_LO: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = VEC_RESET_LO;
                end
                VEC_HI: if (!vec_wait) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = VEC_RESET_HI;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run          <= 1'b0;
            pc           <= RESET_PC;
            op_q         <= '0;
            b1_q         <= '0;
            len_q        <= '0;
            f_to_d_reg   <= '0;
            f_to_d_valid <= 1'b0;
            pc_out       <= '0;
`ifdef NES_RESET_VECTOR_EN
            state        <= VEC_LO;
            vec_wait     <= 1'b0;
`else
            state        <= FETCH_OP;
`endif
        end else begin
            run <= 1'b1;
            if (redirect_ok) begin
                pc           <= redirect_pc;
                f_to_d_valid <= 1'b0;
                state        <= FETCH_OP;
            end else if (run) begin
                case (state)
`ifdef NES_RESET_VECTOR_EN
                    VEC_LO: begin
                        vec_wait <= 1'b0;
                        state    <= VEC_HI;
                    end
                    VEC_HI: begin
                        if (!vec_wait) begin
                            pc[7:0]  <= mem_rdata;
                            vec_wait <= 1'b1;
                        end else begin
                            pc[15:8] <= mem_rdata;
                            state    <= FETCH_OP;
                        end
                    end
`endif
                    FETCH_OP: state <= FETCH_B1;
                    FETCH_B1: begin
                        op_q  <= mem_rdata;
                        len_q <= rd_len;
                        if (rd_len == 2'd1) begin
                            f_to_d_reg   <= pack_fd(mem_rdata, 8'h00, 8'h00);
                            f_to_d_valid <= 1'b1;
                            pc_out       <= pc;
                            state        <= HOLD;
                        end else begin
                            state <= FETCH_B2;
                        end
                    end
                    FETCH_B2: begin
                        b1_q <= mem_rdata;
                        if (len_q == 2'd2) begin
                            f_to_d_reg   <= pack_fd(op_q, mem_rdata, 8'h00);
                            f_to_d_valid <= 1'b1;
                            pc_out       <= pc;
                        end
                        state <= HOLD;
                    end
                    // HOLD entered without valid means the last byte of a
                    // 3-byte instruction is still arriving this cycle.
                    HOLD: begin
                        if (!f_to_d_valid) begin
                            f_to_d_reg   <= pack_fd(op_q, b1_q, mem_rdata);
                            f_to_d_valid <= 1'b1;
                            pc_out       <= pc;
                        end else if (d_ready) begin
                            f_to_d_valid <= 1'b0;
                            pc           <= pc + {14'd0, len_q};
                            state        <= FETCH_OP;
                        end
                    end
                    default: state <= FETCH_OP;
                endcase
            end
        end
    end

endmodule
